uart_rx: RTL and testbench

- Simplex UART receiver; the receive-side counterpart of the FPGA's UART transmitter.
- Samples an asynchronous serial line (8N1, LSB first) at mid-bit and rebuilds bytes.
- Buffers received bytes in a small circular FIFO and hands them to the consumer over a valid/ready handshake.
- Reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Constants and types shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int FrameWidth = 10;
  localparam int DataWidth  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int ticks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream from the receiver to its consumer plus error pulses.
// The receiver is the master; the consumer drives i_ready.
interface uart_rx_if
  import uart_pkg::*;
();

  logic [DataWidth-1:0] o_frame;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_frame_error;
  logic                 o_overrun;

  modport master (
    output o_frame,
    output o_valid,
    output o_frame_error,
    output o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_frame,
    input  o_valid,
    input  o_frame_error,
    input  o_overrun,
    output i_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO with combinational head read; pushes when full are dropped
// and flagged by a registered one-cycle overrun pulse, unless a pop frees the slot.
module uart_rx_fifo #(
  parameter int Depth = 2,
  parameter int Width = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [Width-1:0] push_dat,
  input  logic             pop,
  output logic [Width-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic             overrun
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      head;
  logic [AW:0]      tail;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty so every slot is usable.
  assign empty   = (head == tail);
  assign full    = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[tail[AW-1:0]];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head    <= '0;
      tail    <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) head <= head + 1'b1;
      if (do_pop)  tail <= tail + 1'b1;
      overrun <= push && !do_push;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[head[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling into a small FIFO; o_valid rises the cycle
// after the stop-bit sample. Consumer stalls via i_ready; a full FIFO drops bytes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115200,
  parameter int BufferSize     = 2
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      i_data,
  uart_rx_if.master rx
);

  localparam int TicksPerBit = ticks_per_bit(ClockFrequency, BaudRate);
  localparam int HalfBit     = TicksPerBit / 2;
  localparam int TickW       = $clog2(TicksPerBit);
  localparam int BitW        = $clog2(DataWidth);

  localparam logic [TickW-1:0] TickLast = TickW'(TicksPerBit - 1);
  localparam logic [TickW-1:0] HalfLast = TickW'(HalfBit - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataWidth - 1);

  if (TicksPerBit < 4) begin : g_chk_baud
    $error("uart_rx: ClockFrequency/BaudRate must be at least 4");
  end
  if (BufferSize < 2 || (BufferSize & (BufferSize - 1)) != 0) begin : g_chk_depth
    $error("uart_rx: BufferSize must be a power of 2 and at least 2");
  end
  if (FrameWidth != DataWidth + 2) begin : g_chk_frame
    $error("uart_rx: frame must be start + data + one stop bit");
  end

  logic                 rx_m;
  logic                 rx_s;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [TickW-1:0]     tick;
  logic [TickW-1:0]     tick_nxt;
  logic [BitW-1:0]      bit_cnt;
  logic [BitW-1:0]      bit_nxt;
  logic [DataWidth-1:0] shift;
  logic [DataWidth-1:0] shift_nxt;
  logic                 push;
  logic                 frame_err;
  logic                 frame_err_q;
  logic                 fifo_full;
  logic                 fifo_empty;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_data;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tick        <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      tick        <= tick_nxt;
      bit_cnt     <= bit_nxt;
      shift       <= shift_nxt;
      frame_err_q <= frame_err;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        tick_nxt = '0;
        bit_nxt  = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (tick == HalfLast) begin
          tick_nxt  = '0;
          bit_nxt   = '0;
          // A start bit that is gone by mid-bit was a glitch.
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      DATA: begin
        if (tick == TickLast) begin
          tick_nxt  = '0;
          shift_nxt = {rx_s, shift[DataWidth-1:1]};
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == BitLast) state_nxt = STOP;
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
        if (tick == TickLast) begin
          tick_nxt = '0;
          if (rx_s) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      BREAK: begin
        tick_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .Depth(BufferSize),
    .Width(DataWidth)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push),
    .push_dat(shift),
    .pop     (rx.o_valid && rx.i_ready),
    .pop_dat (rx.o_frame),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .overrun (rx.o_overrun)
  );

  assign rx.o_valid       = !fifo_empty;
  assign rx.o_frame_error = frame_err_q;

  // Full status is implied by overrun; kept as a named net for debug visibility.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 10 clocks per bit, depth-2 and depth-4 instances.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int Tpb = 10;

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  logic clk;
  logic rst_n;
  logic line_a;
  logic line_b;

  uart_rx_if ifa ();
  uart_rx_if ifb ();

  uart_rx #(.ClockFrequency(1_000_000), .BaudRate(100_000), .BufferSize(2)) dut_a (
    .CLK(clk), .RST(rst_n), .i_data(line_a), .rx(ifa)
  );

  uart_rx #(.ClockFrequency(1_000_000), .BaudRate(100_000), .BufferSize(4)) dut_b (
    .CLK(clk), .RST(rst_n), .i_data(line_b), .rx(ifb)
  );

  int checks;
  int failures;
  int vcnt_a, ferr_a, ovr_a;
  int vcnt_b, ferr_b, ovr_b;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.o_valid) vcnt_a++;
    if (ifa.o_valid && ifa.i_ready) q_a.push_back(ifa.o_frame);
    if (ifa.o_frame_error) ferr_a++;
    if (ifa.o_overrun) ovr_a++;
    if (ifb.o_valid) vcnt_b++;
    if (ifb.o_valid && ifb.i_ready) q_b.push_back(ifb.o_frame);
    if (ifb.o_frame_error) ferr_b++;
    if (ifb.o_overrun) ovr_b++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) line_b = v;
    else     line_a = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic stop);
    drive(sel, 1'b0);
    wait_cyc(Tpb);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      wait_cyc(Tpb);
    end
    drive(sel, stop);
    wait_cyc(Tpb);
  endtask

  vec_t vecs[5];

  initial begin
    int n0, v0, f0, o0;
    logic [7:0] stream[4];

    checks = 0; failures = 0;
    vcnt_a = 0; ferr_a = 0; ovr_a = 0;
    vcnt_b = 0; ferr_b = 0; ovr_b = 0;
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'hC3, 1'b1, 1, 0};
    stream  = '{8'h00, 8'hFF, 8'h55, 8'hAA};

    rst_n = 1'b0; line_a = 1'b1; line_b = 1'b1;
    ifa.i_ready = 1'b1; ifb.i_ready = 1'b1;
    wait_cyc(3);
    check("rst_valid", int'(ifa.o_valid), 0);
    check("rst_ferr", int'(ifa.o_frame_error), 0);
    check("rst_ovr", int'(ifa.o_overrun), 0);
    check("rst_valid_b", int'(ifb.o_valid), 0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Single frames, one byte (or one framing error) per entry.
    for (int k = 0; k < 5; k++) begin
      n0 = q_a.size(); v0 = vcnt_a; f0 = ferr_a; o0 = ovr_a;
      send(1'b0, vecs[k].dat, vecs[k].stop);
      drive(1'b0, 1'b1);
      wait_cyc(20);
      check($sformatf("vec%0d_bytes", k), q_a.size() - n0, vecs[k].exp_bytes);
      check($sformatf("vec%0d_vcycles", k), vcnt_a - v0, vecs[k].exp_bytes);
      check($sformatf("vec%0d_ferr", k), ferr_a - f0, vecs[k].exp_ferr);
      check($sformatf("vec%0d_ovr", k), ovr_a - o0, 0);
      if (q_a.size() > n0) check($sformatf("vec%0d_data", k), int'(q_a[n0]), int'(vecs[k].dat));
    end

    // Start-bit glitch.
    n0 = q_a.size(); v0 = vcnt_a;
    line_a = 1'b0;
    wait_cyc(3);
    line_a = 1'b1;
    wait_cyc(20);
    check("glitch_vcycles", vcnt_a - v0, 0);
    check("glitch_state", int'(dut_a.state), int'(IDLE));
    send(1'b0, 8'h5A, 1'b1);
    wait_cyc(20);
    check("glitch_next_bytes", q_a.size() - n0, 1);
    if (q_a.size() > n0) check("glitch_next_data", int'(q_a[n0]), 8'h5A);

    // Framing error followed by a held-low line.
    n0 = q_a.size(); v0 = vcnt_a; f0 = ferr_a;
    send(1'b0, 8'h3C, 1'b0);
    wait_cyc(30);
    check("break_ferr", ferr_a - f0, 1);
    check("break_vcycles", vcnt_a - v0, 0);
    check("break_state", int'(dut_a.state), int'(BREAK));
    line_a = 1'b1;
    wait_cyc(20);
    send(1'b0, 8'h81, 1'b1);
    wait_cyc(20);
    check("break_next_bytes", q_a.size() - n0, 1);
    if (q_a.size() > n0) check("break_next_data", int'(q_a[n0]), 8'h81);

    // Overrun with a stalled consumer.
    ifa.i_ready = 1'b0;
    n0 = q_a.size(); o0 = ovr_a;
    send(1'b0, 8'h11, 1'b1);
    send(1'b0, 8'h22, 1'b1);
    send(1'b0, 8'h33, 1'b1);
    line_a = 1'b1;
    wait_cyc(20);
    check("ovr_pulses", ovr_a - o0, 1);
    check("ovr_valid_held", int'(ifa.o_valid), 1);
    check("ovr_no_pop", q_a.size() - n0, 0);
    ifa.i_ready = 1'b1;
    wait_cyc(5);
    check("ovr_drain_bytes", q_a.size() - n0, 2);
    if (q_a.size() > n0 + 1) begin
      check("ovr_first", int'(q_a[n0]), 8'h11);
      check("ovr_second", int'(q_a[n0+1]), 8'h22);
    end
    check("ovr_empty", int'(ifa.o_valid), 0);

    // Reset in the middle of the data bits with a byte still buffered.
    ifa.i_ready = 1'b0;
    send(1'b0, 8'h42, 1'b1);
    line_a = 1'b1;
    wait_cyc(5);
    check("rstmid_buffered", int'(ifa.o_valid), 1);
    line_a = 1'b0;
    wait_cyc(Tpb);
    line_a = 1'b1;
    wait_cyc(4 * Tpb);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", int'(ifa.o_valid), 0);
    check("rstmid_state", int'(dut_a.state), int'(IDLE));
    wait_cyc(3);
    rst_n = 1'b1;
    ifa.i_ready = 1'b1;
    n0 = q_a.size(); v0 = vcnt_a;
    wait_cyc(20);
    check("rstmid_nobyte", vcnt_a - v0, 0);
    send(1'b0, 8'h7E, 1'b1);
    wait_cyc(20);
    check("rstmid_next_bytes", q_a.size() - n0, 1);
    if (q_a.size() > n0) check("rstmid_next_data", int'(q_a[n0]), 8'h7E);

    // Back-to-back stream into the depth-4 instance.
    n0 = q_b.size(); v0 = vcnt_b; f0 = ferr_b; o0 = ovr_b;
    for (int k = 0; k < 4; k++) send(1'b1, stream[k], 1'b1);
    line_b = 1'b1;
    wait_cyc(20);
    check("stream_bytes", q_b.size() - n0, 4);
    check("stream_vcycles", vcnt_b - v0, 4);
    check("stream_ferr", ferr_b - f0, 0);
    check("stream_ovr", ovr_b - o0, 0);
    for (int k = 0; k < 4; k++) begin
      if (q_b.size() > n0 + k) check($sformatf("stream_data%0d", k), int'(q_b[n0+k]), int'(stream[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
